// File: rtl/calc_ops_pkg.sv
// Shared definitions for the calc_ops datapath: word field positions, opcodes,
// error codes and the operand-unpack FSM state type.
package calc_ops_pkg;

    localparam int unsigned WORD_W   = 48;
    localparam int unsigned PAY_W    = 40;
    localparam int unsigned OP_W     = 2 * PAY_W;

    localparam int unsigned APP_MSB  = 47;
    localparam int unsigned APP_LSB  = 45;
    localparam int unsigned RSVD_BIT = 44;
    localparam int unsigned SEL_BIT  = 43;
    localparam int unsigned IDX_MSB  = 42;
    localparam int unsigned IDX_LSB  = 40;

    localparam logic [2:0] APP_ADD   = 3'b001;
    localparam logic [2:0] APP_MUL   = 3'b010;
    localparam logic [2:0] APP_SHIFT = 3'b011;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_APP     = 2'b01;
    localparam logic [1:0] ERR_SEQ     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StIssue
    } state_e;

    function automatic logic app_legal(input logic [2:0] code);
        return (code == APP_ADD) || (code == APP_MUL) || (code == APP_SHIFT);
    endfunction

endpackage

// File: rtl/calc_word_decode.sv
// Combinational split of a tagged 48-bit word into its fields plus opcode legality.
module calc_word_decode
    import calc_ops_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [2:0]        app,
    output logic              sel,
    output logic [2:0]        idx,
    output logic [PAY_W-1:0]  payload,
    output logic              app_ok
);

    assign app     = word[APP_MSB:APP_LSB];
    assign sel     = word[SEL_BIT];
    assign idx     = word[IDX_MSB:IDX_LSB];
    assign payload = word[PAY_W-1:0];
    assign app_ok  = app_legal(word[APP_MSB:APP_LSB]);

endmodule

// File: rtl/calc_operand_unpack.sv
// Reassembles four tagged words into two 80-bit operands and issues one start per
// frame to the compute core; operands are shadowed so the core sees stable values.
module calc_operand_unpack
    import calc_ops_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              busy,
    output logic              start,
    output logic [2:0]        app,
    output logic              sel,
    output logic [OP_W-1:0]   a,
    output logic [OP_W-1:0]   b,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        err_cnt
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_e            state;
    logic [1:0]        exp_idx;
    logic [TO_W-1:0]   to_cnt;
    logic [2:0]        app_l;
    logic              sel_l;
    logic [OP_W-1:0]   stage_a;
    logic [OP_W-1:0]   stage_b;

    logic [2:0]        w_app;
    logic              w_sel;
    logic [2:0]        w_idx;
    logic [PAY_W-1:0]  w_pay;
    logic              w_app_ok;

    logic              accept;
    logic              to_hit;
    logic              seq_ok;
    logic              frame_head;
    logic              err_fire;
    logic [1:0]        err_kind;

    calc_word_decode u_decode (
        .word    (din),
        .app     (w_app),
        .sel     (w_sel),
        .idx     (w_idx),
        .payload (w_pay),
        .app_ok  (w_app_ok)
    );

    always_comb begin
        accept     = din_valid & din_ready;
        to_hit     = (state == StCollect) && !accept && (to_cnt == TO_W'(TIMEOUT - 1));
        seq_ok     = (w_idx == {1'b0, exp_idx}) && (w_app == app_l) && (w_sel == sel_l);
        frame_head = w_app_ok && (w_idx == 3'd0);
        err_fire   = 1'b0;
        err_kind   = ERR_NONE;
        if (to_hit) begin
            err_fire = 1'b1;
            err_kind = ERR_TIMEOUT;
        end else if (accept) begin
            // Bad opcode outranks any sequencing problem on the same word.
            if (!w_app_ok) begin
                err_fire = 1'b1;
                err_kind = ERR_APP;
            end else if ((state == StIdle && w_idx != 3'd0) ||
                         (state == StCollect && !seq_ok)) begin
                err_fire = 1'b1;
                err_kind = ERR_SEQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            din_ready <= 1'b0;
            exp_idx   <= 2'd0;
            to_cnt    <= '0;
            app_l     <= 3'd0;
            sel_l     <= 1'b0;
            stage_a   <= '0;
            stage_b   <= '0;
            start     <= 1'b0;
            app       <= 3'd0;
            sel       <= 1'b0;
            a         <= '0;
            b         <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_cnt   <= 8'd0;
        end else begin
            start     <= 1'b0;
            err       <= err_fire;
            din_ready <= 1'b1;
            if (err_fire) begin
                err_code <= err_kind;
                if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            end

            case (state)
                StIdle: begin
                    if (accept && frame_head) begin
                        app_l                    <= w_app;
                        sel_l                    <= w_sel;
                        stage_a[OP_W-1 -: PAY_W] <= w_pay;
                        exp_idx                  <= 2'd1;
                        to_cnt                   <= '0;
                        state                    <= StCollect;
                    end
                end
                StCollect: begin
                    if (to_hit) begin
                        state <= StIdle;
                    end else if (accept) begin
                        to_cnt <= '0;
                        if (!w_app_ok) begin
                            state <= StIdle;
                        end else if (seq_ok) begin
                            case (exp_idx)
                                2'd1:    stage_a[PAY_W-1:0]       <= w_pay;
                                2'd2:    stage_b[OP_W-1 -: PAY_W] <= w_pay;
                                default: stage_b[PAY_W-1:0]       <= w_pay;
                            endcase
                            if (exp_idx == 2'd3) begin
                                state     <= StIssue;
                                din_ready <= 1'b0;
                            end else begin
                                exp_idx <= exp_idx + 2'd1;
                            end
                        end else if (frame_head) begin
                            // A fresh idx0 restarts the frame instead of being dropped.
                            app_l                    <= w_app;
                            sel_l                    <= w_sel;
                            stage_a[OP_W-1 -: PAY_W] <= w_pay;
                            exp_idx                  <= 2'd1;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                StIssue: begin
                    if (!busy) begin
                        start <= 1'b1;
                        a     <= stage_a;
                        b     <= stage_b;
                        app   <= app_l;
                        sel   <= sel_l;
                        state <= StIdle;
                    end else begin
                        din_ready <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_operand_unpack.sv
// Scoreboard bench for calc_operand_unpack: directed frames push expected start/err
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_calc_operand_unpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        busy = 1'b0;
    logic        start;
    logic [2:0]  app;
    logic        sel;
    logic [79:0] a;
    logic [79:0] b;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        bit          is_err;
        logic [2:0]  app;
        logic        sel;
        logic [79:0] a;
        logic [79:0] b;
        logic [1:0]  code;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];

    calc_operand_unpack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .busy      (busy),
        .start     (start),
        .app       (app),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .err       (err),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [47:0] mk(input logic [2:0] ap, input logic s,
                                       input logic [2:0] ix, input logic [39:0] pay);
        return {ap, 1'b0, s, ix, pay};
    endfunction

    // Monitor: every start/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (start || err)) begin
            exp_t it;
            chk("start_err_exclusive", {79'd0, start & err}, 80'd0);
            if (sb.size() == 0) begin
                chk("unexpected_event", {78'd0, start, err}, 80'd0);
            end else begin
                it = sb.pop_front();
                chk("event_kind", {78'd0, start, err}, it.is_err ? 80'd1 : 80'd2);
                if (it.is_err) begin
                    chk("err_code", {78'd0, err_code}, {78'd0, it.code});
                    chk("err_cnt", {72'd0, err_cnt}, {72'd0, it.cnt});
                end else begin
                    chk("a", a, it.a);
                    chk("b", b, it.b);
                    chk("app", {77'd0, app}, {77'd0, it.app});
                    chk("sel", {79'd0, sel}, {79'd0, it.sel});
                end
            end
        end
    end

    task automatic push_err(input logic [1:0] code);
        exp_t it;
        if (exp_cnt < 255) exp_cnt++;
        it = '{is_err: 1'b1, app: 3'd0, sel: 1'b0, a: '0, b: '0, code: code,
               cnt: 8'(exp_cnt)};
        sb.push_back(it);
    endtask

    task automatic push_start(input logic [2:0] ap, input logic s,
                              input logic [79:0] va, input logic [79:0] vb);
        exp_t it;
        it = '{is_err: 1'b0, app: ap, sel: s, a: va, b: vb, code: 2'd0, cnt: 8'd0};
        sb.push_back(it);
    endtask

    task automatic send(input logic [47:0] w);
        int n;
        @(negedge clk);
        din       = w;
        din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) chk("din_ready_timeout", 80'd0, 80'd1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [2:0] ap, input logic s,
                              input logic [79:0] va, input logic [79:0] vb);
        send(mk(ap, s, 3'd0, va[79:40]));
        send(mk(ap, s, 3'd1, va[39:0]));
        send(mk(ap, s, 3'd2, vb[79:40]));
        send(mk(ap, s, 3'd3, vb[39:0]));
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 80'(sb.size()), 80'd0);
        repeat (3) @(negedge clk);
    endtask

    localparam logic [79:0] A5    = 80'd5;
    localparam logic [79:0] BM3   = 80'hFFFF_FFFF_FFFF_FFFF_FFFD;
    localparam logic [79:0] MA    = 80'h0123_4567_89AB_CDEF_0011;
    localparam logic [79:0] MB    = 80'h0000_0000_0000_0000_0007;

    initial begin
        // Reset state
        #12;
        chk("rst_din_ready", {79'd0, din_ready}, 80'd0);
        chk("rst_start", {79'd0, start}, 80'd0);
        chk("rst_err_cnt", {72'd0, err_cnt}, 80'd0);
        chk("rst_a", a, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_din_ready", {79'd0, din_ready}, 80'd1);

        // ADD frame, start one cycle after the last word
        push_start(3'b001, 1'b1, A5, BM3);
        send_frame(3'b001, 1'b1, A5, BM3);
        @(posedge clk);
        #1;
        chk("add_latency", {79'd0, start}, 80'd1);
        drain(20);

        // MUL frame held off by busy
        busy = 1'b1;
        push_start(3'b010, 1'b0, MA, MB);
        send_frame(3'b010, 1'b0, MA, MB);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0 || i == 19) begin
                chk("busy_din_ready", {79'd0, din_ready}, 80'd0);
                chk("busy_no_start", {79'd0, start}, 80'd0);
            end
        end
        busy = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_release_start", {79'd0, start}, 80'd1);
        drain(20);
        push_start(3'b011, 1'b1, 80'd1, 80'h85);
        send_frame(3'b011, 1'b1, 80'd1, 80'h85);
        drain(20);

        // idx0, idx1, idx0 restart
        push_err(2'b10);
        push_start(3'b001, 1'b0, 80'h77, 80'h99);
        send(mk(3'b001, 1'b0, 3'd0, 40'h0));
        send(mk(3'b001, 1'b0, 3'd1, 40'h1));
        send(mk(3'b001, 1'b0, 3'd0, 40'h0));
        send(mk(3'b001, 1'b0, 3'd1, 40'h77));
        send(mk(3'b001, 1'b0, 3'd2, 40'h0));
        send(mk(3'b001, 1'b0, 3'd3, 40'h99));
        drain(20);

        // Illegal app in IDLE
        push_err(2'b01);
        send(mk(3'b101, 1'b0, 3'd0, 40'h5));
        drain(20);
        repeat (5) @(negedge clk);
        chk("err_code_held", {78'd0, err_code}, 80'd1);
        chk("a_stable", a, 80'h77);

        // Timeout after two words, then a normal frame
        push_err(2'b11);
        send(mk(3'b010, 1'b1, 3'd0, 40'h0));
        send(mk(3'b010, 1'b1, 3'd1, 40'h3));
        drain(1200);
        push_start(3'b010, 1'b1, 80'h4, 80'h6);
        send_frame(3'b010, 1'b1, 80'h4, 80'h6);
        drain(20);

        // Reset mid-frame
        send(mk(3'b001, 1'b1, 3'd0, 40'h0));
        send(mk(3'b001, 1'b1, 3'd1, 40'h8));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_a", a, 80'd0);
        chk("midrst_app", {77'd0, app}, 80'd0);
        chk("midrst_err_cnt", {72'd0, err_cnt}, 80'd0);
        chk("midrst_err_code", {78'd0, err_code}, 80'd0);
        chk("midrst_din_ready", {79'd0, din_ready}, 80'd0);
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_start", 80'(sb.size()), 80'd0);

        // err_cnt saturation
        for (int i = 0; i < 300; i++) begin
            push_err(2'b01);
            send(mk(3'b000, 1'b0, 3'd0, 40'(i)));
        end
        drain(50);
        chk("err_cnt_sat", {72'd0, err_cnt}, 80'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
